// File: rtl/scan_dec_pkg.sv
// Shared encodings and the one-hot helper used by the scanning decoder.
package scan_dec_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;

  // Select width the helper is built for; other widths use a shift in the decoder.
  localparam int SEL_W = 3;

  function automatic logic [2**SEL_W-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

endpackage

// File: rtl/onehot_dec_n.sv
// Combinational N-to-2^N one-hot decoder with an active-high enable.
module onehot_dec_n
  import scan_dec_pkg::*;
#(
  parameter int N = 3,
  localparam int OUTS = 2**N
) (
  input  logic [N-1:0]    idx,
  input  logic            en,
  output logic [OUTS-1:0] y
);

  logic [OUTS-1:0] full;

  generate
    if (N == SEL_W) begin : g_pkg
      assign full = onehot(idx);
    end else begin : g_shift
      assign full = OUTS'(1) << idx;
    end
  endgenerate

  assign y = en ? full : '0;

endmodule

// File: rtl/scan_decoder_n.sv
// Registered binary-to-one-hot decoder with an autonomous up/down scan mode
// whose index holds for dwell+1 enabled cycles before advancing.
module scan_decoder_n
  import scan_dec_pkg::*;
#(
  parameter int N       = 3,
  parameter int DWELL_W = 8,
  localparam int OUTS   = 2**N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               dir,
  input  logic [N-1:0]       sel,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUTS-1:0]    d,
  output logic [N-1:0]       idx,
  output logic               wrap
);

  logic [DWELL_W-1:0] cnt;
  logic               mode_q;
  logic               mode_chg;
  logic [N-1:0]       idx_n;
  logic [DWELL_W-1:0] cnt_n;
  logic               wrap_n;
  logic [OUTS-1:0]    d_n;

  assign mode_chg = (mode != mode_q);

  always_comb begin
    idx_n  = idx;
    cnt_n  = cnt;
    wrap_n = 1'b0;
    if (mode == MODE_DIRECT) begin
      idx_n = sel;
      cnt_n = '0;
    end else if (load) begin
      idx_n = sel;
      cnt_n = '0;
    end else if (!en) begin
      // Frozen: idx and cnt hold, output blanks via the decoder enable.
    end else if (mode_chg) begin
      // Entering scan restarts the dwell without advancing.
      cnt_n = '0;
    end else if (cnt < dwell) begin
      cnt_n = cnt + DWELL_W'(1);
    end else begin
      cnt_n = '0;
      if (dir == DIR_UP) begin
        idx_n  = idx + N'(1);
        wrap_n = (idx == '1);
      end else begin
        idx_n  = idx - N'(1);
        wrap_n = (idx == '0);
      end
    end
  end

  onehot_dec_n #(.N(N)) u_dec (
    .idx (idx_n),
    .en  (en),
    .y   (d_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      d      <= '0;
      idx    <= '0;
      wrap   <= 1'b0;
      cnt    <= '0;
      mode_q <= MODE_DIRECT;
    end else begin
      d      <= d_n;
      idx    <= idx_n;
      wrap   <= wrap_n;
      cnt    <= cnt_n;
      mode_q <= mode;
    end
  end

endmodule
